// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_multi
//  Description : N-channel button/switch debouncer. Each channel has a 2-FF
//                synchroniser, a ce-qualified stability counter, a registered
//                debounced level and registered rise/fall event pulses.
//                Optional long-press detection is built only when the macro
//                HOLD_DET_EN is defined; otherwise hold is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi #(
    parameter int                  CHANNELS    = 4,
    parameter int                  DB_CYCLES   = 1024,
    parameter logic [CHANNELS-1:0] RESET_VAL   = '0,
    parameter int                  HOLD_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change,
    output logic [CHANNELS-1:0] hold
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] db_nx;
    logic [CHANNELS-1:0] rise_nx;
    logic [CHANNELS-1:0] fall_nx;

    // Elaboration-time sanity checks on the configuration
    if (CHANNELS < 1) begin : g_bad_channels
        $error("debounce_multi: CHANNELS must be >= 1");
    end
    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("debounce_multi: DB_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("debounce_multi: HOLD_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;
        logic             db_nx_ch;
        logic             rise_nx_ch;
        logic             fall_nx_ch;

        // Stability counter next state: any agreement clears progress, a full
        // run of DB_CYCLES ce-qualified disagreements flips the level
        always_comb begin
            cnt_nx     = cnt;
            db_nx_ch   = db_out[i];
            rise_nx_ch = 1'b0;
            fall_nx_ch = 1'b0;
            if (sync2[i] == db_out[i]) begin
                cnt_nx = '0;
            end else if (ce) begin
                if (cnt == CNT_LAST) begin
                    cnt_nx     = '0;
                    db_nx_ch   = sync2[i];
                    rise_nx_ch = sync2[i];
                    fall_nx_ch = ~sync2[i];
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
        end

        // Stability counter register
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_nx;
            end
        end

        assign db_nx[i]   = db_nx_ch;
        assign rise_nx[i] = rise_nx_ch;
        assign fall_nx[i] = fall_nx_ch;
    end

    // Synchronisers, debounced level and event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= RESET_VAL;
            sync2      <= RESET_VAL;
            db_out     <= RESET_VAL;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            sync1      <= button_in;
            sync2      <= sync1;
            db_out     <= db_nx;
            rise       <= rise_nx;
            fall       <= fall_nx;
            any_change <= |(rise_nx | fall_nx);
        end
    end

`ifdef HOLD_DET_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);

    logic [CHANNELS-1:0] hold_nx;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_hold
        logic [HOLD_W-1:0] hcnt;

        // Long-press pulse fires once when the count completes; saturation
        // blocks a repeat until db_out drops and clears the count
        assign hold_nx[i] = db_out[i] & ce & (hcnt == HOLD_LAST);

        // Per-channel press-duration counter, runs only while db_out is high
        always_ff @(posedge clk) begin
            if (reset || !db_out[i]) begin
                hcnt <= '0;
            end else if (ce && hcnt == HOLD_LAST) begin
                hcnt <= HOLD_SAT;
            end else if (ce && hcnt != HOLD_SAT) begin
                hcnt <= hcnt + HOLD_W'(1);
            end
        end
    end

    // Registered long-press pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else begin
            hold <= hold_nx;
        end
    end
`else
    assign hold = '0;
`endif

endmodule
`default_nettype wire
